// File: rtl/sys_pkg.sv
// Shared constants and types for the systolic drain collector.
package sys_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefRow   = 32;
  localparam int unsigned VecCntW  = 16;

  typedef logic [DefWidth-1:0] row_t;
  typedef row_t [DefRow-1:0]   vec_t;

endpackage

// File: rtl/systolic_drain_if.sv
// Downstream valid/ready stream carrying one assembled result vector per transfer.
interface systolic_drain_if #(
  parameter int unsigned ROW   = 32,
  parameter int unsigned WIDTH = 16
);

  logic                   m_valid;
  logic                   m_ready;
  logic [ROW*WIDTH-1:0]   m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, synchronous active-low reset plus soft clear.
module sync_fifo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [DataWidth-1:0]       data_i,
  input  logic                       pop_i,
  output logic [DataWidth-1:0]       data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 wr_en, rd_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/systolic_drain.sv
// Collects skewed per-row results into whole vectors and streams them out via a FIFO.
// Optional macro SYS_DRAIN_RELU_EN clamps negative results to zero at capture.
module systolic_drain
  import sys_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned ROW   = DefRow,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [ROW-1:0]            out_in,
  input  logic [ROW-1:0][WIDTH-1:0] feature_out,
  systolic_drain_if.master          m,
  output logic                      stall,
  output logic                      overflow,
  output logic [VecCntW-1:0]        vec_count
);

  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [ROW-1:0]            slot_full_q, slot_full_d;
  logic [ROW-1:0][WIDTH-1:0] slot_data_q, slot_data_d;
  logic [ROW-1:0][WIDTH-1:0] cap_word;
  logic                      overflow_q, overflow_d;
  logic [VecCntW-1:0]        vec_count_q, vec_count_d;

  logic                      all_full, push, pop;
  logic                      fifo_full, fifo_empty;
  logic [CntW-1:0]           fifo_count;
  logic [ROW*WIDTH-1:0]      fifo_head;

  always_comb begin
    cap_word = feature_out;
`ifdef SYS_DRAIN_RELU_EN
    for (int i = 0; i < ROW; i++) begin
      if (feature_out[i][WIDTH-1]) cap_word[i] = '0;
    end
`endif
  end

  assign all_full = &slot_full_q;
  assign pop      = ~fifo_empty & m.m_ready;
  assign push     = all_full & (~fifo_full | pop);

  // A row strobing on the release edge refills its slot rather than overflowing.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    overflow_d  = overflow_q;
    for (int i = 0; i < ROW; i++) begin
      if (out_in[i] && (!slot_full_q[i] || push)) begin
        slot_data_d[i] = cap_word[i];
        slot_full_d[i] = 1'b1;
      end else if (out_in[i]) begin
        overflow_d = 1'b1;
      end else if (push) begin
        slot_full_d[i] = 1'b0;
      end
    end
    vec_count_d = pop ? vec_count_q + VecCntW'(1) : vec_count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      slot_full_q <= '0;
      slot_data_q <= '0;
      overflow_q  <= 1'b0;
      vec_count_q <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      overflow_q  <= overflow_d;
      vec_count_q <= vec_count_d;
    end
  end

  sync_fifo #(
    .DataWidth (ROW*WIDTH),
    .Depth     (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clear),
    .push_i  (push),
    .data_i  (slot_data_q),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m.m_valid = ~fifo_empty;
  assign m.m_data  = fifo_empty ? '0 : fifo_head;
  assign stall     = (fifo_count >= CntW'(DEPTH-1)) | (all_full & fifo_full);
  assign overflow  = overflow_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Randomised and directed bench for systolic_drain with a queue-based scoreboard.
module tb_systolic_drain;
  import sys_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned R = 4;
  localparam int unsigned D = 4;

  logic                  clk = 1'b0;
  logic                  rst_n, clear;
  logic [R-1:0]          out_in;
  logic [R-1:0][W-1:0]   feature_out;
  logic                  stall, overflow;
  logic [VecCntW-1:0]    vec_count;

  always #5 clk = ~clk;

  systolic_drain_if #(.ROW(R), .WIDTH(W)) mif ();

  systolic_drain #(
    .WIDTH (W),
    .ROW   (R),
    .DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .out_in      (out_in),
    .feature_out (feature_out),
    .m           (mif),
    .stall       (stall),
    .overflow    (overflow),
    .vec_count   (vec_count)
  );

  // Reference model: pending row values, number of vectors waiting downstream.
  logic [W-1:0]   m_slot [R];
  bit             m_have [R];
  int             m_occ;
  bit             m_ovf;
  int unsigned    m_vcnt;
  logic [R*W-1:0] exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] stored(input logic [W-1:0] v);
`ifdef SYS_DRAIN_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic bit model_all();
    for (int i = 0; i < R; i++) if (!m_have[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < R; i++) begin
      m_have[i] = 1'b0;
      m_slot[i] = '0;
    end
    m_occ  = 0;
    m_ovf  = 1'b0;
    m_vcnt = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    chk("m_valid", 64'(mif.m_valid), 64'(m_occ != 0));
    chk("stall", 64'(stall), 64'((m_occ >= int'(D) - 1) || (model_all() && m_occ == int'(D))));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("vec_count", 64'(vec_count), 64'(m_vcnt % 65536));
  endtask

  task automatic step(input logic [R-1:0] oi, input logic [R*W-1:0] data,
                      input logic rdy, input logic clr);
    bit             full_vec, pop, push;
    logic [R*W-1:0] vec;
    out_in      = oi;
    feature_out = data;
    mif.m_ready = rdy;
    clear       = clr;
    if (clr) begin
      model_clear();
    end else begin
      full_vec = model_all();
      pop      = rdy && (m_occ > 0);
      push     = full_vec && (m_occ < int'(D) || pop);
      if (push) begin
        for (int i = 0; i < R; i++) vec[i*W +: W] = m_slot[i];
        exp_q.push_back(vec);
      end
      for (int i = 0; i < R; i++) begin
        if (oi[i]) begin
          if (!m_have[i] || push) begin
            m_slot[i] = stored(data[i*W +: W]);
            m_have[i] = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
        end else if (push) begin
          m_have[i] = 1'b0;
        end
      end
      if (push) m_occ++;
      if (pop) begin
        m_occ--;
        m_vcnt++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step('0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    clear       = 1'b0;
    out_in      = '0;
    feature_out = '0;
    mif.m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    chk("rst_m_valid", 64'(mif.m_valid), 64'd0);
    chk("rst_m_data", 64'(mif.m_data), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_vec_count", 64'(vec_count), 64'd0);
  endtask

  // Scoreboard monitor: every accepted transfer must match the oldest predicted vector.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mif.m_valid === 1'b1 && mif.m_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_vector", 64'(mif.m_data), 64'hDEAD);
      else chk("m_data", 64'(mif.m_data), 64'(exp_q.pop_front()));
    end
  end

  logic [R*W-1:0] relu_exp;

  initial begin
    rst_n       = 1'b0;
    mif.m_ready = 1'b0;
    do_reset();
    do_reset();

    // Skewed one-hot capture, rows 0..3 carrying 1..4.
    for (int k = 0; k < R; k++) step(R'(1) << k, (R*W)'(k + 1) << (k * W), 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    chk("skew_m_data", 64'(mif.m_data), 64'h0004_0003_0002_0001);
    idle(2, 1'b1);
    chk("skew_vec_count", 64'(vec_count), 64'd1);

    // Backpressure: five vectors against a four-deep FIFO.
    for (int k = 0; k < 5; k++) step('1, {R{W'(k)}}, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("bp_stall", 64'(stall), 64'd1);
    step(R'(1), {R{16'h5555}}, 1'b0, 1'b0);
    chk("bp_overflow", 64'(overflow), 64'd1);
    idle(8, 1'b1);
    chk("bp_vec_count", 64'(vec_count), 64'd6);

    // Soft clear with overflow set and FIFO holding vectors.
    for (int k = 0; k < 2; k++) step('1, {R{W'(k + 16'h20)}}, 1'b0, 1'b0);
    idle(1, 1'b0);
    step('0, '0, 1'b0, 1'b1);
    chk("clr_m_valid", 64'(mif.m_valid), 64'd0);
    chk("clr_m_data", 64'(mif.m_data), 64'd0);
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_vec_count", 64'(vec_count), 64'd0);

    // Row 0 refilled on the same edge its completed vector is pushed.
    step('1, {R{16'h1111}}, 1'b1, 1'b0);
    step(R'(1), {R{16'hAAAA}}, 1'b1, 1'b0);
    chk("same_edge_overflow", 64'(overflow), 64'd0);
    step(4'b1110, {R{16'h2222}}, 1'b1, 1'b0);
    idle(2, 1'b0);
    chk("same_edge_row0", 64'(mif.m_data[15:0]), 64'hAAAA);
    idle(3, 1'b1);

    // Reset mid-operation with partial slots and a non-empty FIFO.
    step('1, {R{16'h0101}}, 1'b0, 1'b0);
    step('1, {R{16'h0202}}, 1'b0, 1'b0);
    step(4'b0011, {R{16'h0303}}, 1'b0, 1'b0);
    do_reset();
    step('1, 64'h0D03_0D02_0D01_0D00, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("rst_next_vec_count", 64'(vec_count), 64'd1);

    // Sign handling at capture.
`ifdef SYS_DRAIN_RELU_EN
    relu_exp = 64'h0000_7FFF_0000_0000;
`else
    relu_exp = 64'h0000_7FFF_FFFF_8000;
`endif
    step('1, 64'h0000_7FFF_FFFF_8000, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("relu_m_data", 64'(mif.m_data), 64'(relu_exp));
    idle(2, 1'b1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      step(R'($urandom & $urandom), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    idle(12, 1'b1);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output collector at the drain end of the systolic vector.
- Captures per-row results, which arrive skewed across rows and are flagged by per-row valid strobes. Each row is held until every row of the vector has produced its value.
- The complete vector is then pushed into a small output FIFO and presented downstream on a valid/ready handshake.
- Backpressure to the array controller is given via `stall`.

Parameters:
- WIDTH, 16, bits per row result (signed two's complement)
- ROW, 32, rows in the systolic vector
- DEPTH, 4, output FIFO depth in complete vectors (power of 2, ≥2)

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- clear  input  1  synchronous soft clear of capture state, FIFO and error flag
- out_in  input  ROW  per-row result valid from the array
- feature_out  input  ROW x WIDTH  per-row result data from the array
- m_valid  output  1  assembled vector available
- m_ready  input  1  downstream accepts vector
- m_data  output  ROW*WIDTH  assembled vector; row i at bits [i*WIDTH +: WIDTH]
- stall  output  1  array must stop issuing new vectors
- overflow  output  1  sticky: a row result arrived while its slot was still occupied
- vec_count  output  16  vectors accepted downstream; wraps at 2^16

Behaviour:
- Reset (rst_n=0 at a clk edge), or clear=1: all capture slots empty, FIFO empty, m_valid=0, m_data=0, stall=0, overflow=0, vec_count=0. rst_n has priority over clear.
- Capture:
  - Each row i has slot_data[i] and slot_full[i].
  - On an edge with out_in[i]=1 and slot_full[i]=0: capture feature_out[i] and set slot_full[i].
  - On an edge with out_in[i]=1 and slot_full[i]=1 (and the slot is not being released that edge): data dropped, overflow set. overflow stays set until reset or clear.
- Assembly:
  - all_full = AND of slot_full.
  - When all_full=1 and FIFO not full: push the slot_data vector into the FIFO and clear every slot_full on the same edge.
  - If out_in[i]=1 on that same edge, row i captures into the released slot and slot_full[i] remains 1. Capture wins over release; overflow is not set.
  - When all_full=1 and FIFO is full: hold the slots, no push. Further out_in on full slots set overflow.
- Latency:
  - Last row captured at edge E.
  - Push at edge E+1 (FIFO not full).
  - m_valid=1 from the cycle after E+1, with m_data equal to that vector.
  - Minimum two edges from last capture to m_valid.
- Output handshake:
  - Transfer occurs on an edge with m_valid & m_ready. FIFO head pops and vec_count increments.
  - m_valid/m_data are stable while m_valid=1 and m_ready=0.
  - Push and pop on the same edge with FIFO full: push is allowed (count unchanged).
- stall = (fifo_count ≥ DEPTH-1) | (all_full & fifo_count == DEPTH). Combinational from registered state.
- FIFO order is strictly FIFO. Pointers wrap modulo DEPTH.
- No arithmetic on data except under the optional feature.

Optional Feature:
- Macro: SYS_DRAIN_RELU_EN.
- Defined: at capture, a result with MSB=1 (negative) is stored as 0; non-negative results are stored unchanged. There is no added latency.
- Undefined: results are stored bit-exact.

Decomposition:
- Shared package sys_pkg holds:
  - default WIDTH/ROW constants
  - typedef for a WIDTH-bit row word
  - ROW-element vector type
  - vec_count width constant (16)
- One natural sub-module: sync_fifo (parameterised data width and DEPTH, synchronous active-low reset, push/pop/full/empty/count). It is instantiated once with data width ROW*WIDTH.

Test Plan:
- Skewed capture, ROW=4, WIDTH=16: out_in one-hot walks rows 0..3 on consecutive cycles with data 0x0001..0x0004, m_ready=1. Required: m_valid=1 exactly 2 edges after row-3 capture, m_data={0x0004,0x0003,0x0002,0x0001}, vec_count=1.
- Backpressure: m_ready=0 while 5 vectors are driven (DEPTH=4). Required:
  - stall rises after 3 vectors are pushed.
  - The 4th vector fills the FIFO.
  - The 5th vector is held in the slots.
  - Repeat out_in on row 0 sets overflow=1.
  - Raising m_ready drains 0..4 in order.
- Same-edge release and capture: row 0 out_in asserted (data 0xAAAA) on the push edge of a complete vector. Required: no overflow; the next emitted vector row 0 is 0xAAAA.
- Reset mid-operation: rows 0–1 captured, FIFO holds 2 vectors, rst_n=0 for one edge. Required: m_valid=0, stall=0, overflow=0, vec_count=0. The next full vector emits correctly with no stale rows.
- clear with overflow=1 and FIFO non-empty. Required: all outputs return to reset values on the next edge.
- ReLU: SYS_DRAIN_RELU_EN defined, inputs 0x8000, 0xFFFF, 0x7FFF, 0x0000. Required: m_data rows 0, 0, 0x7FFF, 0. Macro undefined: values pass unchanged.
